// File: rtl/wb_regfile.sv
// Write-back stage of the MEM/WB register: selects the write-back value, commits it to
// a 32x32 register file with write-through read ports, and drives EX-stage forwarding selects.
module wb_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_MemToReg_in,
    input  logic        wb_RegWrite_in,
    input  logic [31:0] MemRes_in,
    input  logic [31:0] ALURes_in,
    input  logic [4:0]  RegDest_in,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    input  logic [4:0]  ex_rs,
    input  logic [4:0]  ex_rt,
    input  logic        exmem_RegWrite,
    input  logic [4:0]  exmem_RegDest,
    output logic [1:0]  fwdA,
    output logic [1:0]  fwdB,
    output logic [31:0] wb_data,
    output logic [31:0] write_count
);

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_MEMWB   = 2'b01;
    localparam logic [1:0] FWD_EXMEM   = 2'b10;

    logic [31:0] regFile [32];
    logic [31:0] commitCount;
    logic        commitEn;

    assign wb_data     = wb_MemToReg_in ? MemRes_in : ALURes_in;
    assign commitEn    = wb_RegWrite_in && (RegDest_in != 5'd0);
    assign write_count = commitCount;

    // Entry 0 is cleared on reset and never written, so it always holds zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regFile[i] <= '0;
            end
            commitCount <= '0;
        end else if (commitEn) begin
            regFile[RegDest_in] <= wb_data;
            commitCount         <= commitCount + 32'd1;
        end
    end

    function automatic logic [31:0] readPort(input logic [4:0] addr);
        if (addr == 5'd0) begin
            return 32'd0;
        end else if (commitEn && (addr == RegDest_in)) begin
            return wb_data;
        end else begin
            return regFile[addr];
        end
    endfunction

    // EX/MEM is younger than MEM/WB, so it wins when both target the same source.
    function automatic logic [1:0] fwdSel(input logic [4:0] src);
        if (exmem_RegWrite && (exmem_RegDest != 5'd0) && (exmem_RegDest == src)) begin
            return FWD_EXMEM;
        end else if (commitEn && (RegDest_in == src)) begin
            return FWD_MEMWB;
        end else begin
            return FWD_REGFILE;
        end
    endfunction

    always_comb begin
        rs_data = readPort(rs_addr);
        rt_data = readPort(rt_addr);
        fwdA    = fwdSel(ex_rs);
        fwdB    = fwdSel(ex_rt);
    end

endmodule
